// File: rtl/sha1_block_feeder_if.sv
// Signal bundle between the SHA-1 block feeder, its message source, the SHA-1 core and the digest sink.
interface sha1_block_feeder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         in_ready;
    logic [511:0] block_data;
    logic         block_start;
    logic         core_done;
    logic [159:0] core_digest;
    logic [159:0] digest_out;
    logic         digest_valid;
    logic         digest_ready;
    logic         err_too_long;
    logic         err_timeout;
    logic         busy;

    // Feeder side
    modport master (
        input  in_data, in_valid, in_last, in_bytes, core_done, core_digest, digest_ready,
        output in_ready, block_data, block_start, digest_out, digest_valid,
               err_too_long, err_timeout, busy
    );

    // Environment side: message source, SHA-1 core and digest sink
    modport slave (
        output in_data, in_valid, in_last, in_bytes, core_done, core_digest, digest_ready,
        input  in_ready, block_data, block_start, digest_out, digest_valid,
               err_too_long, err_timeout, busy
    );
endinterface

// File: rtl/sha1_block_feeder.sv
// SHA-1 block feeder: packs a 0..55 byte message into one padded 512-bit block,
// starts the core, waits for its done edge and hands the digest out on valid/ready.
module sha1_block_feeder #(
    parameter int unsigned START_HOLD   = 4,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    sha1_block_feeder_if.master bus
);
    localparam int unsigned BLK_BYTES = 64;
    localparam int unsigned BLK_W     = 8 * BLK_BYTES;
    localparam int unsigned MSG_MAX   = 55;
    localparam int unsigned TMR_MAX   = (START_HOLD > WAIT_TIMEOUT) ? START_HOLD : WAIT_TIMEOUT;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PAD,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               block_start_q, block_start_d;
    logic               digest_valid_q, digest_valid_d;
    logic               err_too_long_q, err_too_long_d;
    logic               err_timeout_q, err_timeout_d;
    logic               capture;
    logic               done_q;
    logic [BLK_W-1:0]   blk_q;
    logic [159:0]       digest_q;

    logic [7:0]         in_byte [4];
    logic [2:0]         nb;
    logic [6:0]         sum;
    logic               overflow;
    logic               xfer;
    logic               done_edge;
    logic [6:0]         pos;
    logic [BLK_BYTES-1:0] wr_en;
    logic [7:0]         wr_byte [BLK_BYTES];

    // Byte lanes of the incoming word, lane 0 is the first message byte
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign in_byte[g] = bus.in_data[31 - 8*g -: 8];
    end

    assign nb        = !bus.in_last ? 3'd4 : ((bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes);
    assign sum       = 7'(byte_cnt_q) + 7'(nb);
    assign overflow  = sum > 7'(MSG_MAX);
    assign xfer      = bus.in_valid & in_ready_q;
    assign done_edge = bus.core_done & ~done_q;

    // Next-state and registered-output decode
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        timer_d        = timer_q;
        block_start_d  = 1'b0;
        digest_valid_d = 1'b0;
        err_too_long_d = 1'b0;
        err_timeout_d  = 1'b0;
        capture        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (overflow) begin
                        byte_cnt_d = '0;
                        if (bus.in_last) err_too_long_d = 1'b1;
                        else             state_d        = S_DRAIN;
                    end else begin
                        byte_cnt_d = sum[5:0];
                        if (bus.in_last) state_d = S_PAD;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && bus.in_last) begin
                    err_too_long_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            S_PAD: begin
                block_start_d = 1'b1;
                timer_d       = '0;
                state_d       = S_START;
            end
            S_START: begin
                timer_d    = timer_q + 1'b1;
                byte_cnt_d = '0;
                if (timer_q == TMR_W'(START_HOLD - 1)) state_d       = S_WAIT;
                else                                   block_start_d = 1'b1;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (done_edge) begin
                    capture        = 1'b1;
                    digest_valid_d = 1'b1;
                    state_d        = S_OUT;
                end else if (timer_q == TMR_W'(WAIT_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_OUT: begin
                digest_valid_d = 1'b1;
                if (digest_valid_q && bus.digest_ready) begin
                    digest_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
    end

    // State and control output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= '0;
            timer_q        <= '0;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            block_start_q  <= 1'b0;
            digest_valid_q <= 1'b0;
            err_too_long_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            timer_q        <= timer_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            block_start_q  <= block_start_d;
            digest_valid_q <= digest_valid_d;
            err_too_long_q <= err_too_long_d;
            err_timeout_q  <= err_timeout_d;
            done_q         <= bus.core_done;
        end
    end

    // Per-byte block writes: message bytes while collecting, padding and length in S_PAD
    always_comb begin
        wr_en = '0;
        pos   = '0;
        for (int j = 0; j < BLK_BYTES; j++) wr_byte[j] = 8'h00;
        if (state_q == S_IDLE && xfer) begin
            for (int k = 0; k < 4; k++) begin
                pos = 7'(byte_cnt_q) + 7'(k);
                if (3'(k) < nb && pos <= 7'(MSG_MAX)) begin
                    wr_en[pos[5:0]]   = 1'b1;
                    wr_byte[pos[5:0]] = in_byte[k];
                end
            end
        end else if (state_q == S_PAD) begin
            for (int j = 0; j < BLK_BYTES; j++) begin
                if (6'(j) == byte_cnt_q) begin
                    wr_en[j]   = 1'b1;
                    wr_byte[j] = 8'h80;
                end else if (6'(j) > byte_cnt_q) begin
                    wr_en[j] = 1'b1;
                end
            end
            // Bit length L*8 is at most 440, so only the two low length bytes are non-zero
            wr_byte[62] = {7'b0, byte_cnt_q[5]};
            wr_byte[63] = {byte_cnt_q[4:0], 3'b000};
        end
    end

    // Block register, byte 0 in the top lane
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q <= '0;
        end else begin
            for (int j = 0; j < BLK_BYTES; j++) begin
                if (wr_en[j]) blk_q[8*(BLK_BYTES-1-j) +: 8] <= wr_byte[j];
            end
        end
    end

    // Digest capture on the core done edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        digest_q <= '0;
        else if (capture) digest_q <= bus.core_digest;
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.block_start  = block_start_q;
    assign bus.block_data   = blk_q;
    assign bus.digest_out   = digest_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.err_too_long = err_too_long_q;
    assign bus.err_timeout  = err_timeout_q;
endmodule
